ex: RTL and testbench
=====================

# ex

Execute stage of the 5-stage MIPS pipeline, between `id_ex` and `ex_mem`. Performs ALU, shift, compare, HI/LO move and multiply operations in one cycle. DIV/DIVU run on an iterative 32-step divider that holds the pipeline via `stall_req`. Outputs feed `ex_mem` directly; HI/LO operands are forwarded from the MEM and WB stages.

## Interface
- `DIV_ITER`, 32, divider iterations (one quotient bit per cycle)
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `stall`  in  `CTRL_WIDTH`  pipeline control vector; `stall[2]` = EX held
- `alu_op`  in  `ALUOP_WIDTH`  operation code from `id_ex`
- `reg1_data` / `reg2_data`  in  `REG_DATA_WIDTH` each  operand A (rs or shamt) / operand B (rt or immediate)
- `w_reg_addr_in`, `w_reg_en_in`  in  `REG_ADDR_WIDTH`, 1  destination register and its write enable
- `hi_regs_in`, `lo_regs_in`  in  `REG_DATA_WIDTH`  architectural HI/LO
- `mem_hi`, `mem_lo`, `mem_hilo_wen`  in  32/32/1  HI/LO write from `ex_mem` outputs
- `wb_hi`, `wb_lo`, `wb_hilo_wen`  in  32/32/1  HI/LO write from `mem_wb` outputs
- `w_reg_addr_out`, `w_reg_data_out`, `w_reg_en_out`  out  5/32/1  GPR write to `ex_mem`
- `hi_regs_out`, `lo_regs_out`, `hilo_wen_out`  out  32/32/1  HI/LO write to `ex_mem`
- `stall_req`  out  1  request to ctrl to stall IF/ID/EX

## Operation
- While `rst_n`=0, every output is 0 and the divider is in IDLE.
- Effective HI/LO priority: `mem_*` if `mem_hilo_wen`, else `wb_*` if `wb_hilo_wen`, else `*_regs_in`.
- Logic ops: AND, OR, XOR, NOR, LUI (B is pre-shifted by ID).
- Shifts: SLL, SRL, SRA of B by A[4:0].
- Compares: SLT (signed), SLTU (unsigned); result is 0 or 1.
- ADD/SUB: 32-bit wrap. On signed overflow `w_reg_en_out`=0. ADDU/SUBU never suppress.
- MFHI/MFLO: `w_reg_data_out` = effective HI/LO.
- MTHI/MTLO: `hilo_wen_out`=1; the written half is A, the other half is its effective value.
- MULT/MULTU: 64-bit signed/unsigned product; HI = [63:32], LO = [31:0]; `hilo_wen_out`=1; completes in one cycle.
- Divider FSM, states IDLE, BUSY, DONE:
  - IDLE, DIV/DIVU present, B≠0: latch |A|, |B| (raw values for DIVU) and the signs; counter=0; `stall_req`=1; go to BUSY.
  - IDLE, B=0: `stall_req`=1; go to DONE with quotient 0xFFFFFFFF, remainder A.
  - BUSY: one restoring-subtract step per cycle; `stall_req`=1. Leave for DONE when the counter reaches `DIV_ITER`-1.
  - DONE: `stall_req`=0. LO = quotient, negated if the operand signs differed (DIV only). HI = remainder, sign of A (DIV only). `hilo_wen_out`=1.
  - DONE → IDLE when `stall[2]`=0. While `stall[2]`=1, hold DONE and the result.
- Non-divide ops never touch the FSM. `stall_req`=0 outside divider use.

## Timing
- All non-divide results are combinational from the inputs in the same cycle; there is no internal output register.
- DIV, B≠0: cycle 0 accept, cycles 1..32 BUSY, result valid in cycle 33. `stall_req` is high in cycles 0–32, so the instruction occupies EX for 34 cycles.
- Divide by zero: `stall_req` high in cycle 0 only; result in cycle 1.
- Back-to-back DIVs: the second is accepted in the cycle after DONE→IDLE.
- Asynchronous reset mid-divide aborts the operation immediately: IDLE, `stall_req`=0, no HI/LO write.
- Unknown `alu_op`: all outputs 0 except `w_reg_addr_out`, which passes through.

## Structure
- Shared defines file holds `ALUOP_WIDTH`, all `ALUOP_*` codes, `REG_*_WIDTH` and `CTRL_WIDTH`.
- Divider FSM and datapath go in sub-module `div_unit`, ports:
  - inputs: `clk`, `rst_n`, `start`, `signed_op`, `dividend`, `divisor`, `hold`
  - outputs: `busy`, `done`, `quotient`, `remainder`
- `ex` holds the ALU, multiplier and HI/LO forwarding mux.

## Test plan
- ADD 0x7FFFFFFF + 1 → `w_reg_en_out`=0. Same operands with ADDU → data 0x80000000, `w_reg_en_out`=1.
- MTHI A=0x12345678 with `mem_hilo_wen`=1, `mem_lo`=0xAAAA0000 → HI=0x12345678, LO=0xAAAA0000, `hilo_wen_out`=1.
- MULT 0xFFFFFFFE × 3 → HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- DIV −7 / 2 → `stall_req` high 33 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIVU 100/7 → LO=14, HI=2.
- DIV by 0 → one stall cycle, then LO=0xFFFFFFFF, HI=A. Hold `stall[2]`=1 three cycles in DONE → result held, no restart.
- Assert `rst_n`=0 in BUSY cycle 10 → `stall_req` drops immediately. A DIV presented after release starts fresh: 34 cycles in EX, correct result.

Source files
------------

// File: rtl/ex_pkg.sv
// ============================================================================
// ex_pkg : shared ALU opcodes, datapath widths and divider state encoding
// Revision: 1.0
// ============================================================================
`default_nettype none

package ex_pkg;

    localparam int ALUOP_WIDTH    = 8;
    localparam int REG_DATA_WIDTH = 32;
    localparam int REG_ADDR_WIDTH = 5;
    localparam int CTRL_WIDTH     = 6;

    localparam logic [ALUOP_WIDTH-1:0] ALUOP_NOP   = 8'b0000_0000;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_AND   = 8'b0010_0100;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_OR    = 8'b0010_0101;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_XOR   = 8'b0010_0110;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_NOR   = 8'b0010_0111;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_LUI   = 8'b0101_1100;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLL   = 8'b0111_1100;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRL   = 8'b0000_0010;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SRA   = 8'b0000_0011;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLT   = 8'b0010_1010;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SLTU  = 8'b0010_1011;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADD   = 8'b0010_0000;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_ADDU  = 8'b0010_0001;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUB   = 8'b0010_0010;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_SUBU  = 8'b0010_0011;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MFHI  = 8'b0001_0000;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MTHI  = 8'b0001_0001;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MFLO  = 8'b0001_0010;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MTLO  = 8'b0001_0011;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MULT  = 8'b0001_1000;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_MULTU = 8'b0001_1001;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_DIV   = 8'b0001_1010;
    localparam logic [ALUOP_WIDTH-1:0] ALUOP_DIVU  = 8'b0001_1011;

    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    function automatic logic [REG_DATA_WIDTH-1:0] abs32(input logic [REG_DATA_WIDTH-1:0] v);
        return v[REG_DATA_WIDTH-1] ? (~v + 32'd1) : v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ex_div_unit.sv
// ============================================================================
// div_unit : iterative restoring divider, one quotient bit per cycle
// Revision: 1.0
// ============================================================================
`default_nettype none

module div_unit
    import ex_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic                      signed_op,
    input  logic [REG_DATA_WIDTH-1:0] dividend,
    input  logic [REG_DATA_WIDTH-1:0] divisor,
    input  logic                      hold,
    output logic                      busy,
    output logic                      done,
    output logic [REG_DATA_WIDTH-1:0] quotient,
    output logic [REG_DATA_WIDTH-1:0] remainder
);

    localparam int                CNT_W    = (DIV_ITER > 1) ? $clog2(DIV_ITER) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIV_ITER - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);

    div_state_e                r_state;
    div_state_e                w_next;
    logic [CNT_W-1:0]          r_cnt;
    logic [REG_DATA_WIDTH-1:0] r_quot;
    logic [REG_DATA_WIDTH-1:0] r_rem;
    logic [REG_DATA_WIDTH-1:0] r_dsor;
    logic                      r_neg_q;
    logic                      r_neg_r;
    logic [REG_DATA_WIDTH:0]   w_shift;
    logic [REG_DATA_WIDTH:0]   w_diff;
    logic                      w_div_zero;

    assign w_div_zero = (divisor == '0);
    // Trial subtraction on the partial remainder extended by the next dividend bit
    assign w_shift    = {r_rem, r_quot[REG_DATA_WIDTH-1]};
    assign w_diff     = w_shift - {1'b0, r_dsor};

    always_comb begin
        w_next = r_state;
        busy   = 1'b0;
        done   = 1'b0;
        case (r_state)
            DIV_IDLE: begin
                if (start) begin
                    busy   = 1'b1;
                    w_next = w_div_zero ? DIV_DONE : DIV_BUSY;
                end
            end
            DIV_BUSY: begin
                busy = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_next = DIV_DONE;
                end
            end
            DIV_DONE: begin
                done = 1'b1;
                if (!hold) begin
                    w_next = DIV_IDLE;
                end
            end
            default: w_next = DIV_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= DIV_IDLE;
            r_cnt   <= '0;
            r_quot  <= '0;
            r_rem   <= '0;
            r_dsor  <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                DIV_IDLE: begin
                    if (start) begin
                        r_cnt <= '0;
                        if (w_div_zero) begin
                            r_quot  <= '1;
                            r_rem   <= dividend;
                            r_dsor  <= '0;
                            r_neg_q <= 1'b0;
                            r_neg_r <= 1'b0;
                        end else begin
                            r_quot  <= signed_op ? abs32(dividend) : dividend;
                            r_dsor  <= signed_op ? abs32(divisor) : divisor;
                            r_rem   <= '0;
                            r_neg_q <= signed_op & (dividend[REG_DATA_WIDTH-1] ^ divisor[REG_DATA_WIDTH-1]);
                            r_neg_r <= signed_op & dividend[REG_DATA_WIDTH-1];
                        end
                    end
                end
                DIV_BUSY: begin
                    r_cnt <= r_cnt + CNT_ONE;
                    if (!w_diff[REG_DATA_WIDTH]) begin
                        r_rem  <= w_diff[REG_DATA_WIDTH-1:0];
                        r_quot <= {r_quot[REG_DATA_WIDTH-2:0], 1'b1};
                    end else begin
                        r_rem  <= w_shift[REG_DATA_WIDTH-1:0];
                        r_quot <= {r_quot[REG_DATA_WIDTH-2:0], 1'b0};
                    end
                end
                default: ;
            endcase
        end
    end

    assign quotient  = r_neg_q ? (~r_quot + 32'd1) : r_quot;
    assign remainder = r_neg_r ? (~r_rem + 32'd1) : r_rem;

endmodule

`default_nettype wire

// File: rtl/ex.sv
// ============================================================================
// ex : MIPS execute stage - ALU, shifter, multiplier, HI/LO forwarding, divider
// Revision: 1.0
// ============================================================================
`default_nettype none

module ex
    import ex_pkg::*;
#(
    parameter int DIV_ITER = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CTRL_WIDTH-1:0]     stall,
    input  logic [ALUOP_WIDTH-1:0]    alu_op,
    input  logic [REG_DATA_WIDTH-1:0] reg1_data,
    input  logic [REG_DATA_WIDTH-1:0] reg2_data,
    input  logic [REG_ADDR_WIDTH-1:0] w_reg_addr_in,
    input  logic                      w_reg_en_in,
    input  logic [REG_DATA_WIDTH-1:0] hi_regs_in,
    input  logic [REG_DATA_WIDTH-1:0] lo_regs_in,
    input  logic [31:0]               mem_hi,
    input  logic [31:0]               mem_lo,
    input  logic                      mem_hilo_wen,
    input  logic [31:0]               wb_hi,
    input  logic [31:0]               wb_lo,
    input  logic                      wb_hilo_wen,
    output logic [4:0]                w_reg_addr_out,
    output logic [31:0]               w_reg_data_out,
    output logic                      w_reg_en_out,
    output logic [31:0]               hi_regs_out,
    output logic [31:0]               lo_regs_out,
    output logic                      hilo_wen_out,
    output logic                      stall_req
);

    logic [REG_DATA_WIDTH-1:0] w_hi_eff;
    logic [REG_DATA_WIDTH-1:0] w_lo_eff;
    logic [REG_DATA_WIDTH-1:0] w_sum;
    logic [REG_DATA_WIDTH-1:0] w_diff;
    logic                      w_add_ovf;
    logic                      w_sub_ovf;
    logic [63:0]               w_prod_s;
    logic [63:0]               w_prod_u;
    logic                      w_div_start;
    logic                      w_div_busy;
    logic                      w_div_done;
    logic [REG_DATA_WIDTH-1:0] w_div_quot;
    logic [REG_DATA_WIDTH-1:0] w_div_rem;
    logic [REG_DATA_WIDTH-1:0] w_data;
    logic                      w_en;
    logic [REG_DATA_WIDTH-1:0] w_hi_out;
    logic [REG_DATA_WIDTH-1:0] w_lo_out;
    logic                      w_hwen;
    logic                      w_unused_stall;

    assign w_unused_stall = &{1'b0, stall[CTRL_WIDTH-1:3], stall[1:0]};

    // The youngest in-flight HI/LO write wins
    assign w_hi_eff = mem_hilo_wen ? mem_hi : (wb_hilo_wen ? wb_hi : hi_regs_in);
    assign w_lo_eff = mem_hilo_wen ? mem_lo : (wb_hilo_wen ? wb_lo : lo_regs_in);

    assign w_sum     = reg1_data + reg2_data;
    assign w_diff    = reg1_data - reg2_data;
    assign w_add_ovf = (reg1_data[31] == reg2_data[31]) && (w_sum[31] != reg1_data[31]);
    assign w_sub_ovf = (reg1_data[31] != reg2_data[31]) && (w_diff[31] != reg1_data[31]);

    assign w_prod_s = $signed({{32{reg1_data[31]}}, reg1_data}) * $signed({{32{reg2_data[31]}}, reg2_data});
    assign w_prod_u = {32'd0, reg1_data} * {32'd0, reg2_data};

    assign w_div_start = (alu_op == ALUOP_DIV) || (alu_op == ALUOP_DIVU);

    div_unit #(
        .DIV_ITER (DIV_ITER)
    ) u_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (w_div_start),
        .signed_op (alu_op == ALUOP_DIV),
        .dividend  (reg1_data),
        .divisor   (reg2_data),
        .hold      (stall[2]),
        .busy      (w_div_busy),
        .done      (w_div_done),
        .quotient  (w_div_quot),
        .remainder (w_div_rem)
    );

    always_comb begin
        w_data   = '0;
        w_en     = w_reg_en_in;
        w_hi_out = '0;
        w_lo_out = '0;
        w_hwen   = 1'b0;
        case (alu_op)
            ALUOP_NOP:   ;
            ALUOP_AND:   w_data = reg1_data & reg2_data;
            ALUOP_OR:    w_data = reg1_data | reg2_data;
            ALUOP_XOR:   w_data = reg1_data ^ reg2_data;
            ALUOP_NOR:   w_data = ~(reg1_data | reg2_data);
            ALUOP_LUI:   w_data = reg2_data;
            ALUOP_SLL:   w_data = reg2_data << reg1_data[4:0];
            ALUOP_SRL:   w_data = reg2_data >> reg1_data[4:0];
            ALUOP_SRA:   w_data = $signed(reg2_data) >>> reg1_data[4:0];
            ALUOP_SLT:   w_data = {31'd0, ($signed(reg1_data) < $signed(reg2_data))};
            ALUOP_SLTU:  w_data = {31'd0, (reg1_data < reg2_data)};
            ALUOP_ADD: begin
                w_data = w_sum;
                w_en   = w_reg_en_in & ~w_add_ovf;
            end
            ALUOP_ADDU:  w_data = w_sum;
            ALUOP_SUB: begin
                w_data = w_diff;
                w_en   = w_reg_en_in & ~w_sub_ovf;
            end
            ALUOP_SUBU:  w_data = w_diff;
            ALUOP_MFHI:  w_data = w_hi_eff;
            ALUOP_MFLO:  w_data = w_lo_eff;
            ALUOP_MTHI: begin
                w_hi_out = reg1_data;
                w_lo_out = w_lo_eff;
                w_hwen   = 1'b1;
            end
            ALUOP_MTLO: begin
                w_hi_out = w_hi_eff;
                w_lo_out = reg1_data;
                w_hwen   = 1'b1;
            end
            ALUOP_MULT: begin
                w_hi_out = w_prod_s[63:32];
                w_lo_out = w_prod_s[31:0];
                w_hwen   = 1'b1;
            end
            ALUOP_MULTU: begin
                w_hi_out = w_prod_u[63:32];
                w_lo_out = w_prod_u[31:0];
                w_hwen   = 1'b1;
            end
            ALUOP_DIV, ALUOP_DIVU: begin
                if (w_div_done) begin
                    w_hi_out = w_div_rem;
                    w_lo_out = w_div_quot;
                    w_hwen   = 1'b1;
                end
            end
            default: w_en = 1'b0;
        endcase
    end

    // Reset forces every output low regardless of what is presented
    assign w_reg_addr_out = rst_n ? w_reg_addr_in : '0;
    assign w_reg_data_out = rst_n ? w_data : '0;
    assign w_reg_en_out   = rst_n & w_en;
    assign hi_regs_out    = rst_n ? w_hi_out : '0;
    assign lo_regs_out    = rst_n ? w_lo_out : '0;
    assign hilo_wen_out   = rst_n & w_hwen;
    assign stall_req      = rst_n & w_div_busy;

endmodule

`default_nettype wire

// File: tb/tb_ex.sv
// ============================================================================
// tb_ex : self-checking bench for the ex stage (vector table + divide sequences)
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_ex;
    import ex_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [5:0]  stall;
    logic [7:0]  alu_op;
    logic [31:0] reg1_data, reg2_data;
    logic [4:0]  w_reg_addr_in;
    logic        w_reg_en_in;
    logic [31:0] hi_regs_in, lo_regs_in;
    logic [31:0] mem_hi, mem_lo, wb_hi, wb_lo;
    logic        mem_hilo_wen, wb_hilo_wen;
    logic [4:0]  w_reg_addr_out;
    logic [31:0] w_reg_data_out;
    logic        w_reg_en_out;
    logic [31:0] hi_regs_out, lo_regs_out;
    logic        hilo_wen_out;
    logic        stall_req;

    always #5 clk = ~clk;

    ex #(.DIV_ITER(32)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .alu_op         (alu_op),
        .reg1_data      (reg1_data),
        .reg2_data      (reg2_data),
        .w_reg_addr_in  (w_reg_addr_in),
        .w_reg_en_in    (w_reg_en_in),
        .hi_regs_in     (hi_regs_in),
        .lo_regs_in     (lo_regs_in),
        .mem_hi         (mem_hi),
        .mem_lo         (mem_lo),
        .mem_hilo_wen   (mem_hilo_wen),
        .wb_hi          (wb_hi),
        .wb_lo          (wb_lo),
        .wb_hilo_wen    (wb_hilo_wen),
        .w_reg_addr_out (w_reg_addr_out),
        .w_reg_data_out (w_reg_data_out),
        .w_reg_en_out   (w_reg_en_out),
        .hi_regs_out    (hi_regs_out),
        .lo_regs_out    (lo_regs_out),
        .hilo_wen_out   (hilo_wen_out),
        .stall_req      (stall_req)
    );

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        en;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        wen;
        logic        sreq;
    } out_t;

    typedef struct {
        string       name;
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  fsel;
        out_t        exp;
    } vec_t;

    vec_t  vt[$];
    out_t  sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    function automatic out_t mk(input logic [31:0] data, input logic en, input logic [31:0] hi,
                                input logic [31:0] lo, input logic wen);
        out_t o;
        o.addr = 5'd9;
        o.data = data;
        o.en   = en;
        o.hi   = hi;
        o.lo   = lo;
        o.wen  = wen;
        o.sreq = 1'b0;
        return o;
    endfunction

    function automatic out_t sample();
        out_t o;
        o.addr = w_reg_addr_out;
        o.data = w_reg_data_out;
        o.en   = w_reg_en_out;
        o.hi   = hi_regs_out;
        o.lo   = lo_regs_out;
        o.wen  = hilo_wen_out;
        o.sreq = stall_req;
        return o;
    endfunction

    task automatic check(input string nm, input out_t act, input out_t exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got addr=%0d data=%h en=%b hi=%h lo=%h wen=%b sreq=%b | want addr=%0d data=%h en=%b hi=%h lo=%h wen=%b sreq=%b",
                     nm, act.addr, act.data, act.en, act.hi, act.lo, act.wen, act.sreq,
                     exp.addr, exp.data, exp.en, exp.hi, exp.lo, exp.wen, exp.sreq);
        end
    endtask

    task automatic check_int(input string nm, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [1:0] fsel, input logic [31:0] data, input logic en,
                           input logic [31:0] hi, input logic [31:0] lo, input logic wen);
        vec_t v;
        v.name = nm;
        v.op   = op;
        v.a    = a;
        v.b    = b;
        v.fsel = fsel;
        v.exp  = mk(data, en, hi, lo, wen);
        vt.push_back(v);
    endtask

    // Starts at posedge+1 (the accept cycle); returns at posedge+1 just after DONE->IDLE
    task automatic run_div(input string nm, input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] q, input logic [31:0] r, input int exp_stall, input int hold_cyc);
        int   cnt;
        out_t e;
        cnt          = 0;
        alu_op       = op;
        reg1_data    = a;
        reg2_data    = b;
        mem_hilo_wen = 1'b0;
        wb_hilo_wen  = 1'b0;
        stall        = '0;
        e = mk(32'd0, 1'b1, r, q, 1'b1);
        sb_q.push_back(e);
        @(negedge clk);
        while (stall_req && cnt < 200) begin
            cnt++;
            @(negedge clk);
        end
        check_int({nm, "_stall_cycles"}, cnt, exp_stall);
        check(nm, sample(), sb_q.pop_front());
        if (hold_cyc > 0) begin
            stall = 6'b000100;
            for (int i = 0; i < hold_cyc; i++) begin
                @(negedge clk);
                check({nm, "_hold"}, sample(), e);
            end
            stall = '0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        stall         = '0;
        alu_op        = ALUOP_ADD;
        reg1_data     = 32'd1;
        reg2_data     = 32'd2;
        w_reg_addr_in = 5'd9;
        w_reg_en_in   = 1'b1;
        hi_regs_in    = 32'h1111_0000;
        lo_regs_in    = 32'h2222_0000;
        mem_hi        = 32'hDEAD_0000;
        mem_lo        = 32'hAAAA_0000;
        wb_hi         = 32'hBBBB_0001;
        wb_lo         = 32'hCCCC_0003;
        mem_hilo_wen  = 1'b0;
        wb_hilo_wen   = 1'b0;

        //        name      op           A             B             fw    data          en    hi            lo            wen
        add_vec("and",   ALUOP_AND,   32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 32'hF000F000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("or",    ALUOP_OR,    32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 32'hFFF0FFF0, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("xor",   ALUOP_XOR,   32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 32'h0FF00FF0, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("nor",   ALUOP_NOR,   32'hF0F0F0F0, 32'hFF00FF00, 2'd0, 32'h000F000F, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("lui",   ALUOP_LUI,   32'h0,        32'h12340000, 2'd0, 32'h12340000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("sll",   ALUOP_SLL,   32'd4,        32'h0000000F, 2'd0, 32'h000000F0, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("srl",   ALUOP_SRL,   32'd4,        32'h80000000, 2'd0, 32'h08000000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("sra",   ALUOP_SRA,   32'd4,        32'h80000000, 2'd0, 32'hF8000000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("sra_m", ALUOP_SRA,   32'h24,       32'h80000000, 2'd0, 32'hF8000000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("slt",   ALUOP_SLT,   32'hFFFFFFFF, 32'd1,        2'd0, 32'd1,        1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("sltu",  ALUOP_SLTU,  32'hFFFFFFFF, 32'd1,        2'd0, 32'd0,        1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("add_ov",ALUOP_ADD,   32'h7FFFFFFF, 32'd1,        2'd0, 32'h80000000, 1'b0, 32'h0,        32'h0,        1'b0);
        add_vec("addu",  ALUOP_ADDU,  32'h7FFFFFFF, 32'd1,        2'd0, 32'h80000000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("add",   ALUOP_ADD,   32'hFFFFFFFF, 32'hFFFFFFFF, 2'd0, 32'hFFFFFFFE, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("sub_ov",ALUOP_SUB,   32'h80000000, 32'd1,        2'd0, 32'h7FFFFFFF, 1'b0, 32'h0,        32'h0,        1'b0);
        add_vec("subu",  ALUOP_SUBU,  32'h80000000, 32'd1,        2'd0, 32'h7FFFFFFF, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("mfhi_a",ALUOP_MFHI,  32'h0,        32'h0,        2'd0, 32'h11110000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("mfhi_w",ALUOP_MFHI,  32'h0,        32'h0,        2'd2, 32'hBBBB0001, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("mfhi_p",ALUOP_MFHI,  32'h0,        32'h0,        2'd3, 32'hDEAD0000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("mflo_p",ALUOP_MFLO,  32'h0,        32'h0,        2'd3, 32'hAAAA0000, 1'b1, 32'h0,        32'h0,        1'b0);
        add_vec("mthi",  ALUOP_MTHI,  32'h12345678, 32'h0,        2'd1, 32'h0,        1'b1, 32'h12345678, 32'hAAAA0000, 1'b1);
        add_vec("mtlo",  ALUOP_MTLO,  32'h00000055, 32'h0,        2'd2, 32'h0,        1'b1, 32'hBBBB0001, 32'h00000055, 1'b1);
        add_vec("mult",  ALUOP_MULT,  32'hFFFFFFFE, 32'd3,        2'd0, 32'h0,        1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b1);
        add_vec("multu", ALUOP_MULTU, 32'hFFFFFFFE, 32'd3,        2'd0, 32'h0,        1'b1, 32'h00000002, 32'hFFFFFFFA, 1'b1);
        add_vec("unk",   8'hFF,       32'h12345678, 32'h9ABCDEF0, 2'd3, 32'h0,        1'b0, 32'h0,        32'h0,        1'b0);

        #12;
        check("reset", sample(), '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        foreach (vt[i]) begin
            alu_op       = vt[i].op;
            reg1_data    = vt[i].a;
            reg2_data    = vt[i].b;
            mem_hilo_wen = vt[i].fsel[0];
            wb_hilo_wen  = vt[i].fsel[1];
            sb_q.push_back(vt[i].exp);
            @(negedge clk);
            check(vt[i].name, sample(), sb_q.pop_front());
            @(posedge clk);
            #1;
        end

        run_div("div_m7_2",  ALUOP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 33, 0);
        run_div("div_7_m2",  ALUOP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1,        33, 0);
        run_div("divu_max",  ALUOP_DIVU, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, 32'd0,        33, 0);
        run_div("divu_100_7",ALUOP_DIVU, 32'd100,      32'd7,        32'd14,       32'd2,        33, 0);
        run_div("div_by0",   ALUOP_DIV,  32'h00001234, 32'd0,        32'hFFFFFFFF, 32'h00001234, 1,  3);

        alu_op = ALUOP_NOP;
        @(negedge clk);
        check("idle_after_div", sample(), mk(32'd0, 1'b1, 32'd0, 32'd0, 1'b0));
        @(posedge clk);
        #1;

        alu_op    = ALUOP_DIVU;
        reg1_data = 32'd100;
        reg2_data = 32'd7;
        repeat (10) @(posedge clk);
        #1;
        check_int("busy_cycle10", int'(stall_req), 1);
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_abort", sample(), '0);
        @(negedge clk);
        alu_op = ALUOP_NOP;
        rst_n  = 1'b1;
        @(posedge clk);
        #1;
        run_div("divu_after_rst", ALUOP_DIVU, 32'd100, 32'd7, 32'd14, 32'd2, 33, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
